// File: rtl/bus_pkg.sv
// Shared bus encodings, FSM states and access-size helpers.
// Imported by the memory responder and the CPU mem stage.
package bus_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LB   = 3'd1;
    localparam logic [2:0] RD_LBU  = 3'd2;
    localparam logic [2:0] RD_LH   = 3'd3;
    localparam logic [2:0] RD_LHU  = 3'd4;
    localparam logic [2:0] RD_LW   = 3'd5;
    localparam logic [2:0] RD_LWU  = 3'd6;
    localparam logic [2:0] RD_LD   = 3'd7;

    localparam logic [2:0] WR_NONE = 3'd0;
    localparam logic [2:0] WR_SB   = 3'd1;
    localparam logic [2:0] WR_SH   = 3'd2;
    localparam logic [2:0] WR_SW   = 3'd3;
    localparam logic [2:0] WR_SD   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] rd;
        logic [2:0] lane;
        logic       store;
        logic       err;
    } req_t;

    // log2 of the access width in bytes
    function automatic logic [1:0] rd_size(input logic [2:0] rd);
        case (rd)
            RD_LB, RD_LBU: rd_size = 2'd0;
            RD_LH, RD_LHU: rd_size = 2'd1;
            RD_LD:         rd_size = 2'd3;
            default:       rd_size = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] wr_size(input logic [2:0] wr);
        case (wr)
            WR_SH:   wr_size = 2'd1;
            WR_SW:   wr_size = 2'd2;
            WR_SD:   wr_size = 2'd3;
            default: wr_size = 2'd0;
        endcase
    endfunction

    function automatic logic misaligned_f(
        input logic [1:0] size,
        input logic [2:0] lane
    );
        case (size)
            2'd1:    misaligned_f = lane[0];
            2'd2:    misaligned_f = |lane[1:0];
            2'd3:    misaligned_f = |lane;
            default: misaligned_f = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Memory bus between a requester (master) and the memory responder (slave).
// Requests are sampled by the responder; results come back with bus_ready.
interface bus_mem_responder_if;
    import bus_pkg::*;

    logic [2:0]      bus_rd_ctrl;
    logic [2:0]      bus_wr_ctrl;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_din;
    logic [XLEN-1:0] bus_dout;
    logic            bus_ready;
    logic            bus_busy;
    logic            bus_err;

    modport master (
        output bus_rd_ctrl,
        output bus_wr_ctrl,
        output bus_addr,
        output bus_din,
        input  bus_dout,
        input  bus_ready,
        input  bus_busy,
        input  bus_err
    );

    modport slave (
        input  bus_rd_ctrl,
        input  bus_wr_ctrl,
        input  bus_addr,
        input  bus_din,
        output bus_dout,
        output bus_ready,
        output bus_busy,
        output bus_err
    );

endinterface

// File: rtl/bus_lane_align.sv
// Byte-lane load extract/extend and store mask/merge for one doubleword.
// Purely combinational; lane is the byte offset inside the doubleword.
module bus_lane_align
    import bus_pkg::*;
(
    input  logic [2:0]      rd_ctrl,
    input  logic [2:0]      wr_ctrl,
    input  logic [2:0]      lane,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] wshift;
    logic [7:0]      mask_base;
    logic [7:0]      mask;

    always_comb begin
        rshift = rdata >> {lane, 3'b000};
        load_data = {32'b0, rshift[31:0]};
        case (rd_ctrl)
            RD_LB:   load_data = {{56{rshift[7]}}, rshift[7:0]};
            RD_LBU:  load_data = {56'b0, rshift[7:0]};
            RD_LH:   load_data = {{48{rshift[15]}}, rshift[15:0]};
            RD_LHU:  load_data = {48'b0, rshift[15:0]};
            RD_LW:   load_data = {{32{rshift[31]}}, rshift[31:0]};
            RD_LD:   load_data = rshift;
            default: load_data = {32'b0, rshift[31:0]};
        endcase
    end

    always_comb begin
        case (wr_ctrl)
            WR_SB:   mask_base = 8'h01;
            WR_SH:   mask_base = 8'h03;
            WR_SW:   mask_base = 8'h0F;
            WR_SD:   mask_base = 8'hFF;
            default: mask_base = 8'h00;
        endcase
        mask = mask_base << lane;
        wshift = wdata << {lane, 3'b000};
        merged = rdata;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = wshift[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Single-port doubleword memory behind the bus: accepts one access from IDLE,
// commits stores on acceptance and answers after LATENCY cycles.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int              LATENCY   = 1
) (
    input logic                clk,
    input logic                rst,
    bus_mem_responder_if.slave mem_bus
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [XLEN-1:0] SPAN     = XLEN'(DEPTH) << 3;
    localparam logic [2:0]      LAT_INIT = 3'(LATENCY - 1);

    state_e          state_q;
    state_e          state_d;
    logic [2:0]      cnt_q;
    logic [2:0]      cnt_d;
    logic            accept;
    logic            capture;

    logic [2:0]      wr_eff;
    logic [2:0]      rd_eff;
    logic            is_store;
    logic            conflict;
    logic            misaligned;
    logic            in_range;
    logic            req_err;
    logic            we;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] offset;
    logic [AW-1:0]   idx;

    req_t            req_q;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   cur_idx;
    logic [2:0]      cur_lane;
    logic [XLEN-1:0] dout_q;
    logic            err_q;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;

    logic [XLEN-1:0] mem [DEPTH];

    // Request decode; the 65-bit difference flags addresses below BASE_ADDR
    always_comb begin
        wr_eff = (mem_bus.bus_wr_ctrl <= WR_SD) ? mem_bus.bus_wr_ctrl : WR_NONE;
        is_store = (mem_bus.bus_rd_ctrl == RD_NONE) && (wr_eff != WR_NONE);
        conflict = (mem_bus.bus_rd_ctrl != RD_NONE) && (wr_eff != WR_NONE);
        rd_eff = mem_bus.bus_rd_ctrl;
        if ((mem_bus.bus_rd_ctrl == RD_NONE) && (wr_eff == WR_NONE)) begin
            rd_eff = RD_LWU;
        end
        diff = {1'b0, mem_bus.bus_addr} - {1'b0, BASE_ADDR};
        offset = diff[XLEN-1:0];
        in_range = !diff[XLEN] && (offset < SPAN);
        idx = offset[AW+2:3];
        if (is_store) begin
            misaligned = misaligned_f(wr_size(wr_eff), mem_bus.bus_addr[2:0]);
        end else begin
            misaligned = misaligned_f(rd_size(rd_eff), mem_bus.bus_addr[2:0]);
        end
        req_err = conflict || misaligned || !in_range;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        accept = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                accept = 1'b1;
                cnt_d = LAT_INIT;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            req_q <= '0;
            idx_q <= '0;
            dout_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            if (accept) begin
                req_q <= '{
                    rd: rd_eff,
                    lane: mem_bus.bus_addr[2:0],
                    store: is_store,
                    err: req_err
                };
                idx_q <= idx;
            end
            if (capture) begin
                dout_q <= (req_q.err || req_q.store) ? '0 : load_data;
                err_q <= req_q.err;
            end
        end
    end

    // Merge uses the live address in IDLE, the load extract uses the latched one
    assign cur_idx = (state_q == ST_IDLE) ? idx : idx_q;
    assign cur_lane = (state_q == ST_IDLE) ? mem_bus.bus_addr[2:0] : req_q.lane;
    assign we = accept && rst && is_store && !req_err;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[cur_idx] <= merged;
        end
    end

    bus_lane_align u_align (
        .rd_ctrl   (req_q.rd),
        .wr_ctrl   (wr_eff),
        .lane      (cur_lane),
        .rdata     (mem[cur_idx]),
        .wdata     (mem_bus.bus_din),
        .load_data (load_data),
        .merged    (merged)
    );

    assign mem_bus.bus_dout = dout_q;
    assign mem_bus.bus_err = err_q;
    assign mem_bus.bus_ready = (state_q == ST_RESP);
    assign mem_bus.bus_busy = (state_q != ST_IDLE);

endmodule
